// File: rtl/pic_host_master_pkg.sv
// Shared types and constants for the 8259 host-side bus master.
package pic_host_master_pkg;

  // Bus-cycle timing phases.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } seq_state_t;

  // Kind of bus cycle, selects which strobe is pulsed.
  typedef enum logic [1:0] {
    CYC_WR,
    CYC_RD,
    CYC_INTA
  } cyc_t;

  // Operation the sequencer is currently running.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_INIT,
    OP_OCW,
    OP_RD,
    OP_INTA
  } op_t;

  // ICW bit positions.
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW4_UPM  = 0;

  // Step after ICW index `step`: {more, next_step}. ICW3 is only written
  // in cascade mode, ICW4 only when ICW1 asks for it.
  function automatic logic [2:0] icw_next(input logic [1:0] step,
                                          input logic [7:0] icw1);
    logic [2:0] r;
    r = 3'b000;
    case (step)
      2'd0: r = {1'b1, 2'd1};
      2'd1: if (!icw1[ICW1_SNGL])    r = {1'b1, 2'd2};
            else if (icw1[ICW1_IC4]) r = {1'b1, 2'd3};
      2'd2: if (icw1[ICW1_IC4])      r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pic_host_master_if.sv
// PIC-side bus: chip select, strobes, address and data.
interface pic_host_master_if;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       inta_n;
  logic       a0;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;

  modport master (output cs_n, wr_n, rd_n, inta_n, a0, d_out, d_oe,
                  input  d_in);
  modport slave  (input  cs_n, wr_n, rd_n, inta_n, a0, d_out, d_oe,
                  output d_in);
endinterface

// File: rtl/pic_bus_cycle.sv
// SETUP/STROBE/HOLD/GAP timing engine for one PIC bus cycle. A new cycle
// may be started from IDLE or in the final clock of the previous cycle so
// sequences run back to back without an idle clock.
module pic_bus_cycle
  import pic_host_master_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  cyc_t       i_type,
  input  logic       i_a0,
  input  logic [7:0] i_wdata,
  output logic       o_hold,
  output logic       o_end,
  output logic [7:0] o_rdata,
  pic_host_master_if.master bus
);

  localparam logic [3:0] PW_M1  = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_M1 = 4'((GAP_W > 0) ? GAP_W - 1 : 0);

  seq_state_t r_state;
  cyc_t       r_type;
  logic [3:0] r_cnt;
  logic [7:0] r_rdata;

  assign o_hold  = (r_state == ST_HOLD);
  assign o_end   = (r_state == ST_GAP && r_cnt == 4'd0) ||
                   (r_state == ST_HOLD && GAP_W == 0);
  assign o_rdata = r_rdata;

  // Phase sequencing with registered bus outputs; a start overrides the
  // last-clock transition so cycles chain directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_type     <= CYC_WR;
      r_cnt      <= 4'd0;
      r_rdata    <= 8'h00;
      bus.cs_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.rd_n   <= 1'b1;
      bus.inta_n <= 1'b1;
      bus.a0     <= 1'b0;
      bus.d_out  <= 8'h00;
      bus.d_oe   <= 1'b0;
    end else begin
      case (r_state)
        ST_SETUP: begin
          r_state    <= ST_STROBE;
          r_cnt      <= PW_M1;
          bus.wr_n   <= (r_type != CYC_WR);
          bus.rd_n   <= (r_type != CYC_RD);
          bus.inta_n <= (r_type != CYC_INTA);
        end
        ST_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state    <= ST_HOLD;
            r_rdata    <= bus.d_in;
            bus.wr_n   <= 1'b1;
            bus.rd_n   <= 1'b1;
            bus.inta_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          r_state   <= (GAP_W == 0) ? ST_IDLE : ST_GAP;
          r_cnt     <= GAP_M1;
          bus.cs_n  <= 1'b1;
          bus.a0    <= 1'b0;
          bus.d_out <= 8'h00;
          bus.d_oe  <= 1'b0;
        end
        ST_GAP: begin
          if (r_cnt == 4'd0) r_state <= ST_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: ;
      endcase
      if (i_start) begin
        r_state   <= ST_SETUP;
        r_type    <= i_type;
        bus.cs_n  <= (i_type == CYC_INTA);
        bus.a0    <= i_a0;
        bus.d_out <= (i_type == CYC_WR) ? i_wdata : 8'h00;
        bus.d_oe  <= (i_type == CYC_WR);
      end
    end
  end

endmodule

// File: rtl/pic_host_master.sv
// Host-side master for an 8259 PIC: ICW programming, OCW writes, status
// reads and interrupt acknowledge, arbitrated at idle by fixed priority.
module pic_host_master
  import pic_host_master_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_req,
  input  logic [7:0]  icw1,
  input  logic [7:0]  icw2,
  input  logic [7:0]  icw3,
  input  logic [7:0]  icw4,
  input  logic        ocw_req,
  input  logic [7:0]  ocw_data,
  input  logic        ocw_a0,
  input  logic        rd_req,
  input  logic        rd_a0,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        int_in,
  output logic [15:0] vec_data,
  output logic        vec_valid,
  output logic        busy,
  output logic        inited,
  pic_host_master_if.master bus
);

  op_t         r_op;
  logic [1:0]  r_step;
  logic [7:0]  r_icw1, r_icw2, r_icw3, r_icw4;
  logic        r_busy, r_inited;
  logic [7:0]  r_rd_data;
  logic        r_rd_valid;
  logic [15:0] r_vec_acc, r_vec_data;
  logic        r_vec_valid;

  logic        w_hold, w_end;
  logic [7:0]  w_rdata;
  op_t         w_acc;
  logic        w_8086, w_inta_more, w_chain;
  logic [2:0]  w_icw_nx;
  logic [1:0]  w_nstep;
  logic        w_start, w_a0;
  cyc_t        w_type;
  logic [7:0]  w_wdata;
  logic [15:0] w_vec_acc;

  assign w_8086      = r_icw4[ICW4_UPM] & r_icw1[ICW1_IC4];
  assign w_icw_nx    = icw_next(r_step, r_icw1);
  assign w_inta_more = w_8086 ? (r_step == 2'd0) : (r_step != 2'd2);
  assign w_chain     = (r_op == OP_INIT && w_icw_nx[2]) ||
                       (r_op == OP_INTA && w_inta_more);
  assign w_nstep     = (r_op == OP_INIT) ? w_icw_nx[1:0] : r_step + 2'd1;

  // Fixed-priority pick among requests, only while idle.
  always_comb begin
    w_acc = OP_NONE;
    if (!r_busy) begin
      if (init_req)                w_acc = OP_INIT;
      else if (r_inited && ocw_req) w_acc = OP_OCW;
      else if (r_inited && rd_req)  w_acc = OP_RD;
      else if (r_inited && int_in)  w_acc = OP_INTA;
    end
  end

  // Cycle launched into the engine: a freshly accepted op or the next
  // step of the running sequence.
  always_comb begin
    w_start = 1'b0;
    w_type  = CYC_WR;
    w_a0    = 1'b0;
    w_wdata = 8'h00;
    case (w_acc)
      OP_INIT: begin w_start = 1'b1; w_wdata = icw1; end
      OP_OCW:  begin w_start = 1'b1; w_a0 = ocw_a0; w_wdata = ocw_data; end
      OP_RD:   begin w_start = 1'b1; w_type = CYC_RD; w_a0 = rd_a0; end
      OP_INTA: begin w_start = 1'b1; w_type = CYC_INTA; end
      default: begin
        if (w_end && w_chain) begin
          w_start = 1'b1;
          if (r_op == OP_INIT) begin
            w_a0 = 1'b1;
            case (w_nstep)
              2'd1:    w_wdata = r_icw2;
              2'd2:    w_wdata = r_icw3;
              default: w_wdata = r_icw4;
            endcase
          end else begin
            w_type = CYC_INTA;
          end
        end
      end
    endcase
  end

  // Vector bytes land on INTA pulse 2 (low) and pulse 3 (high).
  always_comb begin
    w_vec_acc = r_vec_acc;
    if (w_hold && r_op == OP_INTA) begin
      if (r_step == 2'd1)      w_vec_acc = {8'h00, w_rdata};
      else if (r_step == 2'd2) w_vec_acc[15:8] = w_rdata;
    end
  end

  pic_bus_cycle #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) u_cyc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_type  (w_type),
    .i_a0    (w_a0),
    .i_wdata (w_wdata),
    .o_hold  (w_hold),
    .o_end   (w_end),
    .o_rdata (w_rdata),
    .bus     (bus)
  );

  // Sequencer: accept, step through the sequence, finish and report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= OP_NONE;
      r_step      <= 2'd0;
      r_icw1      <= 8'h00;
      r_icw2      <= 8'h00;
      r_icw3      <= 8'h00;
      r_icw4      <= 8'h00;
      r_busy      <= 1'b0;
      r_inited    <= 1'b0;
      r_rd_data   <= 8'h00;
      r_rd_valid  <= 1'b0;
      r_vec_acc   <= 16'h0000;
      r_vec_data  <= 16'h0000;
      r_vec_valid <= 1'b0;
    end else begin
      r_rd_valid  <= 1'b0;
      r_vec_valid <= 1'b0;
      if (w_acc != OP_NONE) begin
        r_op   <= w_acc;
        r_step <= 2'd0;
        r_busy <= 1'b1;
        if (w_acc == OP_INIT) begin
          r_icw1   <= icw1;
          r_icw2   <= icw2;
          r_icw3   <= icw3;
          r_icw4   <= icw4;
          r_inited <= 1'b0;
        end
      end else if (r_busy) begin
        r_vec_acc <= w_vec_acc;
        if (w_hold && r_op == OP_RD) begin
          r_rd_data  <= w_rdata;
          r_rd_valid <= 1'b1;
        end
        if (w_end) begin
          if (w_chain) begin
            r_step <= w_nstep;
          end else begin
            r_busy <= 1'b0;
            r_op   <= OP_NONE;
            if (r_op == OP_INIT) r_inited <= 1'b1;
            if (r_op == OP_INTA) begin
              r_vec_data  <= w_vec_acc;
              r_vec_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign busy      = r_busy;
  assign inited    = r_inited;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign vec_data  = r_vec_data;
  assign vec_valid = r_vec_valid;

endmodule

// File: tb/tb_pic_host_master.sv
// Bench for pic_host_master: a bus monitor pops expected cycles from a
// scoreboard queue; scenario tasks check completion, timing and results.
module tb_pic_host_master;
  import pic_host_master_pkg::*;

  typedef struct {
    int         kind;   // 0 write, 1 read, 2 inta
    logic       a0;
    logic [7:0] data;
  } ev_t;

  logic        clk, rst_n;
  logic        init_req, ocw_req, ocw_a0, rd_req, rd_a0, int_in;
  logic [7:0]  icw1, icw2, icw3, icw4, ocw_data, rd_data;
  logic        rd_valid, vec_valid, busy, inited;
  logic [15:0] vec_data;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [7:0] din_q[$];

  pic_host_master_if bus();

  pic_host_master #(.PULSE_W(2), .GAP_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .ocw_req(ocw_req), .ocw_data(ocw_data), .ocw_a0(ocw_a0),
    .rd_req(rd_req), .rd_a0(rd_a0), .rd_data(rd_data), .rd_valid(rd_valid),
    .int_in(int_in), .vec_data(vec_data), .vec_valid(vec_valid),
    .busy(busy), .inited(inited), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_ev(input int kind, input logic a0, input logic [7:0] data);
    ev_t e;
    e.kind = kind; e.a0 = a0; e.data = data;
    exp_q.push_back(e);
  endtask

  // Waits for busy to rise then fall, then `tail` more clocks, recording
  // valid pulses and the negedge index at which each first appeared.
  task automatic wait_idle(input int tail, output int nbusy, output bit tmo,
                           output int nvv, output logic [15:0] vdat, output int vv_at,
                           output int nrv, output logic [7:0] rdat, output int rv_at);
    int n, t;
    nbusy = 0; tmo = 1'b1; nvv = 0; vdat = 16'h0; vv_at = -1;
    nrv = 0; rdat = 8'h0; rv_at = -1; n = 0; t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (vec_valid) begin nvv++; vdat = vec_data; if (vv_at < 0) vv_at = n; end
      if (rd_valid)  begin nrv++; rdat = rd_data;  if (rv_at < 0) rv_at = n; end
      if (t < 0) begin
        if (busy) nbusy++;
        else if (nbusy > 0) begin tmo = 1'b0; t = 0; end
      end else begin
        t++;
      end
      if (t >= tail) break;
    end
  endtask

  // Bus monitor: scoreboard compare at each strobe fall, width at each rise.
  initial begin : monitor
    logic pw, pr, pi, fall, anylow;
    int lowcnt, kind;
    ev_t e;
    pw = 1'b1; pr = 1'b1; pi = 1'b1; lowcnt = 0;
    bus.d_in = 8'h00;
    forever begin
      @(negedge clk);
      fall   = (pw & ~bus.wr_n) | (pr & ~bus.rd_n) | (pi & ~bus.inta_n);
      anylow = ~(bus.wr_n & bus.rd_n & bus.inta_n);
      if (fall) begin
        kind = !bus.wr_n ? 0 : (!bus.rd_n ? 1 : 2);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: kind=%0d a0=%0b d_out=%02h, no cycle expected",
                   kind, bus.a0, bus.d_out);
        end else begin
          e = exp_q.pop_front();
          if (kind !== e.kind || bus.a0 !== e.a0 || (kind == 0 && bus.d_out !== e.data)) begin
            errors++;
            $display("FAIL bus_cycle: got kind=%0d a0=%0b d_out=%02h, want kind=%0d a0=%0b d_out=%02h",
                     kind, bus.a0, bus.d_out, e.kind, e.a0, e.data);
          end
        end
        checks++;
        if (bus.cs_n !== (kind == 2) || bus.d_oe !== (kind == 0) ||
            $countones({bus.wr_n, bus.rd_n, bus.inta_n}) != 2) begin
          errors++;
          $display("FAIL bus_ctrl: cs_n=%0b d_oe=%0b strobes=%03b for kind=%0d",
                   bus.cs_n, bus.d_oe, {bus.wr_n, bus.rd_n, bus.inta_n}, kind);
        end
        if (kind != 0 && din_q.size() > 0) bus.d_in = din_q.pop_front();
        lowcnt = 1;
      end else if (anylow) begin
        lowcnt++;
      end else if (lowcnt > 0) begin
        if (rst_n) begin
          checks++;
          if (lowcnt != 2) begin
            errors++;
            $display("FAIL pulse_width: got %0d clks, want 2", lowcnt);
          end
        end
        lowcnt = 0;
      end
      pw = bus.wr_n; pr = bus.rd_n; pi = bus.inta_n;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.cs_n, bus.wr_n, bus.rd_n, bus.inta_n, bus.a0, bus.d_oe} !== 6'b111100 ||
        bus.d_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: cs/wr/rd/inta/a0/oe=%06b d_out=%02h, want 111100 00",
               {bus.cs_n, bus.wr_n, bus.rd_n, bus.inta_n, bus.a0, bus.d_oe}, bus.d_out);
    end
    checks++;
    if ({busy, inited, rd_valid, vec_valid} !== 4'b0000 || rd_data !== 8'h00 ||
        vec_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_status: busy/inited/rv/vv=%04b rd=%02h vec=%04h, want 0000 00 0000",
               {busy, inited, rd_valid, vec_valid}, rd_data, vec_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic do_init(input logic [7:0] c1, c2, c3, c4, input int want_busy,
                         input string name);
    int nb, nvv, vva, nrv, rva; bit tmo; logic [15:0] vd; logic [7:0] rd;
    icw1 = c1; icw2 = c2; icw3 = c3; icw4 = c4;
    @(posedge clk); #1; init_req = 1'b1;
    @(posedge clk); #1; init_req = 1'b0;
    checks++;
    if (inited !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: inited=%0b busy=%0b, want 0 1", name, inited, busy);
    end
    wait_idle(2, nb, tmo, nvv, vd, vva, nrv, rd, rva);
    checks++;
    if (tmo || nb != want_busy) begin
      errors++;
      $display("FAIL %s_busy: busy clks=%0d timeout=%0b, want %0d", name, nb, tmo, want_busy);
    end
    checks++;
    if (inited !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_done: inited=%0b pending=%0d, want 1 0", name, inited, exp_q.size());
    end
  endtask

  task automatic test_init_single();
    push_ev(0, 1'b0, 8'h13); push_ev(0, 1'b1, 8'h20); push_ev(0, 1'b1, 8'h01);
    do_init(8'h13, 8'h20, 8'h55, 8'h01, 15, "init_single");
  endtask

  task automatic test_init_cascade();
    push_ev(0, 1'b0, 8'h11); push_ev(0, 1'b1, 8'h28);
    push_ev(0, 1'b1, 8'h04); push_ev(0, 1'b1, 8'h00);
    do_init(8'h11, 8'h28, 8'h04, 8'h00, 20, "init_cascade");
  endtask

  task automatic test_inta(input logic [7:0] b1, b2, b3, input int npulse,
                           input logic [15:0] want, input string name);
    int nb, nvv, vva, nrv, rva; bit tmo; logic [15:0] vd; logic [7:0] rd;
    for (int i = 0; i < npulse; i++) push_ev(2, 1'b0, 8'h00);
    din_q.push_back(b1); din_q.push_back(b2);
    if (npulse == 3) din_q.push_back(b3);
    @(posedge clk); #1; int_in = 1'b1;
    @(posedge clk); #1; int_in = 1'b0;
    wait_idle(5, nb, tmo, nvv, vd, vva, nrv, rd, rva);
    checks++;
    if (tmo || nb != 5 * npulse) begin
      errors++;
      $display("FAIL %s_busy: busy clks=%0d timeout=%0b, want %0d", name, nb, tmo, 5 * npulse);
    end
    checks++;
    if (nvv != 1 || vd !== want || vva != nb + 1) begin
      errors++;
      $display("FAIL %s_vec: pulses=%0d vec=%04h at=%0d, want 1 %04h at=%0d",
               name, nvv, vd, vva, want, nb + 1);
    end
    checks++;
    if (exp_q.size() != 0 || nrv != 0) begin
      errors++;
      $display("FAIL %s_tail: pending=%0d rd_valid=%0d, want 0 0", name, exp_q.size(), nrv);
    end
  endtask

  task automatic test_read();
    int nb, nvv, vva, nrv, rva; bit tmo; logic [15:0] vd; logic [7:0] rd;
    push_ev(1, 1'b1, 8'h00);
    din_q.push_back(8'h5A);
    @(posedge clk); #1; rd_req = 1'b1; rd_a0 = 1'b1;
    @(posedge clk); #1; rd_req = 1'b0; rd_a0 = 1'b0;
    wait_idle(3, nb, tmo, nvv, vd, vva, nrv, rd, rva);
    checks++;
    if (tmo || nb != 5 || nrv != 1 || rd !== 8'h5A || rva != 5 || nvv != 0) begin
      errors++;
      $display("FAIL read: busy=%0d rv=%0d rd=%02h at=%0d vv=%0d, want 5 1 5a 5 0",
               nb, nrv, rd, rva, nvv);
    end
  endtask

  task automatic test_priority();
    int nb, nvv, vva, nrv, rva; bit tmo; logic [15:0] vd; logic [7:0] rd;
    push_ev(0, 1'b0, 8'h20);
    for (int i = 0; i < 3; i++) push_ev(2, 1'b0, 8'h00);
    din_q.push_back(8'h00); din_q.push_back(8'h78); din_q.push_back(8'h56);
    @(posedge clk); #1;
    ocw_req = 1'b1; ocw_data = 8'h20; ocw_a0 = 1'b0; rd_req = 1'b1; rd_a0 = 1'b1; int_in = 1'b1;
    @(posedge clk); #1; ocw_req = 1'b0; rd_req = 1'b0;
    wait_idle(0, nb, tmo, nvv, vd, vva, nrv, rd, rva);
    checks++;
    if (tmo || nb != 5 || exp_q.size() != 3) begin
      errors++;
      $display("FAIL prio_ocw: busy=%0d timeout=%0b pending=%0d, want 5 0 3", nb, tmo, exp_q.size());
    end
    @(posedge clk); #1; int_in = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_ack_start: busy=%0b, want 1", busy);
    end
    wait_idle(5, nb, tmo, nvv, vd, vva, nrv, rd, rva);
    checks++;
    if (tmo || nvv != 1 || vd !== 16'h5678 || nrv != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL prio_ack: vv=%0d vec=%04h rv=%0d pending=%0d, want 1 5678 0 0",
               nvv, vd, nrv, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    push_ev(0, 1'b0, 8'h13); push_ev(0, 1'b1, 8'h20);
    icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'h00; icw4 = 8'h01;
    @(posedge clk); #1; init_req = 1'b1;
    @(posedge clk); #1; init_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.wr_n && bus.a0) begin found = 1'b1; break; end
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (!found || {bus.wr_n, bus.rd_n, bus.inta_n, bus.cs_n} !== 4'b1111 ||
        busy !== 1'b0 || inited !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid: found=%0b strobes/cs=%04b busy=%0b inited=%0b pending=%0d, want 1 1111 0 0 0",
               found, {bus.wr_n, bus.rd_n, bus.inta_n, bus.cs_n}, busy, inited, exp_q.size());
    end
    rst_n = 1'b1;
    // Requests other than init must be ignored until programmed again.
    @(posedge clk); #1; ocw_req = 1'b1; rd_req = 1'b1; int_in = 1'b1;
    @(posedge clk); #1; ocw_req = 1'b0; rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1; int_in = 1'b0;
    checks++;
    if (busy !== 1'b0 || inited !== 1'b0) begin
      errors++;
      $display("FAIL uninit_ignore: busy=%0b inited=%0b, want 0 0", busy, inited);
    end
    push_ev(0, 1'b0, 8'h13); push_ev(0, 1'b1, 8'h20); push_ev(0, 1'b1, 8'h01);
    do_init(8'h13, 8'h20, 8'h00, 8'h01, 15, "reinit");
  endtask

  initial begin
    init_req = 0; ocw_req = 0; ocw_a0 = 0; rd_req = 0; rd_a0 = 0; int_in = 0;
    icw1 = 0; icw2 = 0; icw3 = 0; icw4 = 0; ocw_data = 0;
    test_reset();
    test_init_single();
    test_inta(8'hFF, 8'h0A, 8'h00, 2, 16'h000A, "inta_8086");
    test_init_cascade();
    test_inta(8'hCD, 8'h34, 8'h12, 3, 16'h1234, "inta_8080");
    test_read();
    test_priority();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
